// File: rtl/wb_ram_slave.sv
// Wishbone classic single-port RAM slave: word-aligned window at BASE_ADDR, byte-lane writes,
// WAIT_STATES cycles of latency before a one-cycle ack (hit) or err (miss/misaligned).
module wb_ram_slave #(
   parameter int          ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          WAIT_STATES = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] wbs_addr_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   output logic [31:0] wbs_dat_o,
   output logic        wbs_ack_o,
   output logic        wbs_err_o
);

   localparam int          DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [32:0] WIN_BYTES = 33'(4) << ADDR_WIDTH;
   localparam logic [3:0]  WS_INIT   = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                r_state;
   logic [3:0]            r_cnt;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic                  r_we;
   logic                  r_hit;
   logic [31:0]           r_wdat;
   logic [3:0]            r_sel;
   logic                  r_ack;
   logic                  r_err;
   logic [31:0]           r_rdat;
   logic [31:0]           r_mem [DEPTH];

   logic [31:0]           w_off;
   logic                  w_req;
   logic                  w_hit_in;
   logic [ADDR_WIDTH-1:0] w_idx_in;
   logic                  w_go_direct;
   logic                  w_go_wait;
   logic                  w_enter;
   logic                  w_hit;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [31:0]           w_wdat;
   logic [3:0]            w_sel;
   logic                  w_wr_en;

   // BASE_ADDR is window-aligned, so the offset's low bits equal the address's low bits.
   assign w_off    = wbs_addr_i - BASE_ADDR;
   assign w_req    = wbs_cyc_i & wbs_stb_i;
   assign w_hit_in = ({1'b0, w_off} < WIN_BYTES) && (w_off[1:0] == 2'b00);
   assign w_idx_in = w_off[ADDR_WIDTH+1:2];

   // With zero wait states the response is set up on the sampling edge straight from the bus.
   assign w_go_direct = (r_state == S_IDLE) && w_req && (WAIT_STATES == 0);
   assign w_go_wait   = (r_state == S_WAIT) && wbs_cyc_i && (r_cnt == 4'd1);
   assign w_enter     = (w_go_direct || w_go_wait) && !rst_i;

   assign w_hit   = w_go_direct ? w_hit_in  : r_hit;
   assign w_we    = w_go_direct ? wbs_we_i  : r_we;
   assign w_idx   = w_go_direct ? w_idx_in  : r_idx;
   assign w_wdat  = w_go_direct ? wbs_dat_i : r_wdat;
   assign w_sel   = w_go_direct ? wbs_sel_i : r_sel;
   assign w_wr_en = w_enter && w_hit && w_we;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_we    <= 1'b0;
         r_hit   <= 1'b0;
         r_wdat  <= 32'd0;
         r_sel   <= 4'd0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdat  <= 32'd0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_idx   <= w_idx_in;
                  r_we    <= wbs_we_i;
                  r_hit   <= w_hit_in;
                  r_wdat  <= wbs_dat_i;
                  r_sel   <= wbs_sel_i;
                  r_cnt   <= WS_INIT;
                  r_state <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (!wbs_cyc_i)
                  r_state <= S_IDLE;
               else if (r_cnt == 4'd1)
                  r_state <= S_RESP;
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
         if (w_enter) begin
            r_ack <= w_hit;
            r_err <= !w_hit;
            if (w_hit && !w_we)
               r_rdat <= r_mem[w_idx];
         end
      end
   end

   // Storage is deliberately not reset; w_wr_en already excludes reset cycles.
   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         for (int k = 0; k < 4; k++) begin
            if (w_sel[k])
               r_mem[w_idx][8*k +: 8] <= w_wdat[8*k +: 8];
         end
      end
   end

   assign wbs_dat_o = r_rdat;
   assign wbs_ack_o = r_ack;
   assign wbs_err_o = r_err;

endmodule
